alu_wb_buffer: RTL and testbench

Completion-side receiver for the integer ALU: captures each finished ALU op (done/rd/rob_index/result plus CSR, exception and branch sideband) into a small in-order FIFO. It drains entries to the physical register file write port, the ROB completion port, the CSR write port and the BTB/gshare update port. It back-pressures the ALU through stall_o, which feeds the ALU's stall input.

---
 rtl/alu_wb_buffer.sv | 134 +++++++++++++
 tb/tb_alu_wb_buffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// ALU completion buffer: queues finished ALU ops in order and drains them to the
// register file, ROB, CSR file and branch predictor, back-pressuring the ALU when full.
module alu_wb_buffer #(
  parameter int XLEN                 = 64,
  parameter int PHY_REG_ADDR_WIDTH   = 6,
  parameter int ROB_INDEX_WIDTH      = 4,
  parameter int VIRTUAL_ADDR_LEN     = 39,
  parameter int CSR_ADDR_LEN         = 12,
  parameter int EXCEPTION_CODE_WIDTH = 4,
  parameter int DEPTH                = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  output logic                            stall_o,
  input  logic                            alu_done_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]   alu_rd_addr_i,
  input  logic [ROB_INDEX_WIDTH-1:0]      alu_rob_index_i,
  input  logic [XLEN-1:0]                 alu_result_i,
  input  logic                            alu_exception_valid_i,
  input  logic [EXCEPTION_CODE_WIDTH-1:0] alu_ecause_i,
  input  logic                            alu_csr_valid_i,
  input  logic                            alu_csr_write_i,
  input  logic [CSR_ADDR_LEN-1:0]         alu_csr_address_i,
  input  logic [XLEN-1:0]                 alu_csr_data_i,
  input  logic                            alu_jump_i,
  input  logic                            alu_branch_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     alu_pc_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     alu_next_pc_i,
  output logic                            prf_wr_en_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0]   prf_wr_addr_o,
  output logic [XLEN-1:0]                 prf_wr_data_o,
  output logic                            rob_cpl_valid_o,
  input  logic                            rob_cpl_ready_i,
  output logic [ROB_INDEX_WIDTH-1:0]      rob_cpl_index_o,
  output logic                            rob_cpl_exception_o,
  output logic [EXCEPTION_CODE_WIDTH-1:0] rob_cpl_ecause_o,
  output logic                            csr_wr_valid_o,
  input  logic                            csr_wr_ready_i,
  output logic [CSR_ADDR_LEN-1:0]         csr_wr_address_o,
  output logic [XLEN-1:0]                 csr_wr_data_o,
  output logic                            bpu_upd_valid_o,
  output logic                            bpu_upd_jump_o,
  output logic                            bpu_upd_branch_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]     bpu_upd_pc_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]     bpu_upd_next_pc_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PHY_REG_ADDR_WIDTH-1:0]   rd_q     [DEPTH];
  logic [ROB_INDEX_WIDTH-1:0]      rob_q    [DEPTH];
  logic [XLEN-1:0]                 res_q    [DEPTH];
  logic                            exc_q    [DEPTH];
  logic [EXCEPTION_CODE_WIDTH-1:0] ecause_q [DEPTH];
  logic                            csr_v_q  [DEPTH];
  logic                            csr_w_q  [DEPTH];
  logic [CSR_ADDR_LEN-1:0]         csr_a_q  [DEPTH];
  logic [XLEN-1:0]                 csr_d_q  [DEPTH];
  logic                            jump_q   [DEPTH];
  logic                            br_q     [DEPTH];
  logic [VIRTUAL_ADDR_LEN-1:0]     pc_q     [DEPTH];
  logic [VIRTUAL_ADDR_LEN-1:0]     npc_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             gate, head_valid, needs_csr, cpl_ok, push, pop, head_ok;

  // Strobes are suppressed in reset and flush cycles so nothing half-commits.
  assign gate       = rstn & ~flush;
  assign stall_o    = (count_q == FULL);
  assign head_valid = (count_q != '0);
  assign needs_csr  = csr_v_q[rd_ptr_q] & csr_w_q[rd_ptr_q] & ~exc_q[rd_ptr_q];
  assign cpl_ok     = head_valid & (~needs_csr | csr_wr_ready_i) & gate;
  assign push       = alu_done_i & ~stall_o & gate;
  assign pop        = cpl_ok & rob_cpl_ready_i;
  assign head_ok    = pop & ~exc_q[rd_ptr_q];

  assign rob_cpl_valid_o = cpl_ok;
  assign csr_wr_valid_o  = head_valid & needs_csr & rob_cpl_ready_i & gate;
  assign prf_wr_en_o     = head_ok & (rd_q[rd_ptr_q] != '0);
  assign bpu_upd_valid_o = head_ok & (jump_q[rd_ptr_q] | br_q[rd_ptr_q]);

  assign prf_wr_addr_o       = head_valid ? rd_q[rd_ptr_q]     : '0;
  assign prf_wr_data_o       = head_valid ? res_q[rd_ptr_q]    : '0;
  assign rob_cpl_index_o     = head_valid ? rob_q[rd_ptr_q]    : '0;
  assign rob_cpl_exception_o = head_valid & exc_q[rd_ptr_q];
  assign rob_cpl_ecause_o    = head_valid ? ecause_q[rd_ptr_q] : '0;
  assign csr_wr_address_o    = head_valid ? csr_a_q[rd_ptr_q]  : '0;
  assign csr_wr_data_o       = head_valid ? csr_d_q[rd_ptr_q]  : '0;
  assign bpu_upd_jump_o      = head_valid & jump_q[rd_ptr_q];
  assign bpu_upd_branch_o    = head_valid & br_q[rd_ptr_q];
  assign bpu_upd_pc_o        = head_valid ? pc_q[rd_ptr_q]     : '0;
  assign bpu_upd_next_pc_o   = head_valid ? npc_q[rd_ptr_q]    : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr_q]     <= alu_rd_addr_i;
      rob_q[wr_ptr_q]    <= alu_rob_index_i;
      res_q[wr_ptr_q]    <= alu_result_i;
      exc_q[wr_ptr_q]    <= alu_exception_valid_i;
      ecause_q[wr_ptr_q] <= alu_ecause_i;
      csr_v_q[wr_ptr_q]  <= alu_csr_valid_i;
      csr_w_q[wr_ptr_q]  <= alu_csr_write_i;
      csr_a_q[wr_ptr_q]  <= alu_csr_address_i;
      csr_d_q[wr_ptr_q]  <= alu_csr_data_i;
      jump_q[wr_ptr_q]   <= alu_jump_i;
      br_q[wr_ptr_q]     <= alu_branch_i;
      pc_q[wr_ptr_q]     <= alu_pc_i;
      npc_q[wr_ptr_q]    <= alu_next_pc_i;
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: captured ops are queued in an independent
// model and every cycle the DUT strobes and head fields are compared against it.
module tb_alu_wb_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [5:0]  rd;
    logic [3:0]  rob;
    logic [63:0] res;
    logic        exc;
    logic [3:0]  ec;
    logic        cv;
    logic        cw;
    logic [11:0] ca;
    logic [63:0] cd;
    logic        j;
    logic        b;
    logic [38:0] pc;
    logic [38:0] npc;
  } op_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic done = 1'b0;
  logic rob_rdy = 1'b0;
  logic csr_rdy = 1'b1;
  op_t  cur = '0;

  logic        stall_o, prf_wr_en_o, rob_cpl_valid_o, rob_cpl_exception_o;
  logic        csr_wr_valid_o, bpu_upd_valid_o, bpu_upd_jump_o, bpu_upd_branch_o;
  logic [5:0]  prf_wr_addr_o;
  logic [63:0] prf_wr_data_o, csr_wr_data_o;
  logic [3:0]  rob_cpl_index_o, rob_cpl_ecause_o;
  logic [11:0] csr_wr_address_o;
  logic [38:0] bpu_upd_pc_o, bpu_upd_next_pc_o;

  int   checks = 0;
  int   failures = 0;
  op_t  q[$];
  logic last_push = 1'b0;

  always #5 clk = ~clk;

  alu_wb_buffer dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall_o(stall_o),
    .alu_done_i(done), .alu_rd_addr_i(cur.rd), .alu_rob_index_i(cur.rob),
    .alu_result_i(cur.res), .alu_exception_valid_i(cur.exc), .alu_ecause_i(cur.ec),
    .alu_csr_valid_i(cur.cv), .alu_csr_write_i(cur.cw), .alu_csr_address_i(cur.ca),
    .alu_csr_data_i(cur.cd), .alu_jump_i(cur.j), .alu_branch_i(cur.b),
    .alu_pc_i(cur.pc), .alu_next_pc_i(cur.npc),
    .prf_wr_en_o(prf_wr_en_o), .prf_wr_addr_o(prf_wr_addr_o), .prf_wr_data_o(prf_wr_data_o),
    .rob_cpl_valid_o(rob_cpl_valid_o), .rob_cpl_ready_i(rob_rdy),
    .rob_cpl_index_o(rob_cpl_index_o), .rob_cpl_exception_o(rob_cpl_exception_o),
    .rob_cpl_ecause_o(rob_cpl_ecause_o),
    .csr_wr_valid_o(csr_wr_valid_o), .csr_wr_ready_i(csr_rdy),
    .csr_wr_address_o(csr_wr_address_o), .csr_wr_data_o(csr_wr_data_o),
    .bpu_upd_valid_o(bpu_upd_valid_o), .bpu_upd_jump_o(bpu_upd_jump_o),
    .bpu_upd_branch_o(bpu_upd_branch_o), .bpu_upd_pc_o(bpu_upd_pc_o),
    .bpu_upd_next_pc_o(bpu_upd_next_pc_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [5:0] rd, input logic [3:0] rob,
                             input logic [63:0] res, input logic exc, input logic [3:0] ec,
                             input logic cv, input logic cw, input logic [11:0] ca,
                             input logic [63:0] cd, input logic j, input logic b);
    op_t o;
    o.rd = rd; o.rob = rob; o.res = res; o.exc = exc; o.ec = ec;
    o.cv = cv; o.cw = cw; o.ca = ca; o.cd = cd; o.j = j; o.b = b;
    o.pc  = 39'h40_0000 + 39'(rob) * 39'd4;
    o.npc = o.pc + 39'h100;
    return o;
  endfunction

  // Model evaluation on the falling edge; its state update stands for the next rising edge.
  always @(negedge clk) begin
    op_t  h;
    logic ne, nc, g, ecv, ecsr, epop, push;
    ne   = (q.size() != 0);
    h    = ne ? q[0] : '0;
    nc   = h.cv & h.cw & ~h.exc;
    g    = rstn & ~flush;
    ecv  = ne & (~nc | csr_rdy) & g;
    ecsr = ne & nc & rob_rdy & g;
    epop = ecv & rob_rdy;
    chk("stall", stall_o, 64'(q.size() == DEPTH));
    chk("cpl_valid", rob_cpl_valid_o, 64'(ecv));
    chk("csr_valid", csr_wr_valid_o, 64'(ecsr));
    chk("prf_en", prf_wr_en_o, 64'(epop & ~h.exc & (h.rd != 0)));
    chk("bpu_valid", bpu_upd_valid_o, 64'(epop & ~h.exc & (h.j | h.b)));
    if (rstn) begin
      chk("cpl_index", rob_cpl_index_o, 64'(h.rob));
      chk("cpl_exc", rob_cpl_exception_o, 64'(h.exc));
      chk("cpl_ecause", rob_cpl_ecause_o, 64'(h.ec));
      chk("prf_addr", prf_wr_addr_o, 64'(h.rd));
      chk("prf_data", prf_wr_data_o, h.res);
      chk("csr_addr", csr_wr_address_o, 64'(h.ca));
      chk("csr_data", csr_wr_data_o, h.cd);
      chk("bpu_flags", {bpu_upd_jump_o, bpu_upd_branch_o}, 64'({h.j, h.b}));
      chk("bpu_pc", bpu_upd_pc_o, 64'(h.pc));
      chk("bpu_npc", bpu_upd_next_pc_o, 64'(h.npc));
    end
    push = done & (q.size() != DEPTH) & g;
    last_push = push;
    if (!g) q.delete();
    else begin
      if (epop) void'(q.pop_front());
      if (push) q.push_back(cur);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t o);
    cur  = o;
    done = 1'b1;
  endtask

  task automatic wait_cap();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_push) begin
        done = 1'b0;
        return;
      end
    end
    chk("cap_timeout", 64'd0, 64'd1);
    done = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rstn = 1'b1;
    chk("rst_stall", stall_o, 64'd0);
    chk("rst_cpl", rob_cpl_valid_o, 64'd0);
    chk("rst_data", prf_wr_data_o, 64'd0);

    // single op
    rob_rdy = 1'b1;
    drive(mk(6'd5, 4'd3, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 0));
    wait_cap();
    chk("single_cpl", rob_cpl_valid_o, 64'd1);
    chk("single_idx", rob_cpl_index_o, 64'd3);
    chk("single_prf", {prf_wr_en_o, prf_wr_addr_o}, {57'd0, 1'b1, 6'd5});
    chk("single_data", prf_wr_data_o, 64'h1234);
    tick();
    chk("single_empty", rob_cpl_valid_o, 64'd0);

    // fill and backpressure
    rob_rdy = 1'b0;
    for (int r = 0; r < 4; r++) begin
      drive(mk(6'(r + 1), 4'(r), 64'(100 + r), 0, 0, 0, 0, 0, 0, r[0], r[1]));
      wait_cap();
    end
    chk("full_stall", stall_o, 64'd1);
    drive(mk(6'd9, 4'd4, 64'h44, 0, 0, 0, 0, 0, 0, 1, 0));
    repeat (3) begin
      tick();
      chk("full_nocap", last_push, 64'd0);
    end
    rob_rdy = 1'b1;
    wait_cap();
    repeat (8) tick();
    chk("fill_drained", 64'(q.size()), 64'd0);

    // rd=0 and exception
    drive(mk(6'd0, 4'd6, 64'h77, 0, 0, 0, 0, 0, 0, 0, 1));
    wait_cap();
    chk("rd0_noprf", prf_wr_en_o, 64'd0);
    drive(mk(6'd7, 4'd8, 64'h88, 1, 4'd2, 0, 0, 0, 0, 1, 0));
    wait_cap();
    chk("exc_flag", {rob_cpl_exception_o, rob_cpl_ecause_o}, {59'd0, 1'b1, 4'd2});
    chk("exc_noupd", {prf_wr_en_o, bpu_upd_valid_o}, 64'd0);
    tick();

    // CSR write held by the CSR file
    csr_rdy = 1'b0;
    drive(mk(6'd3, 4'd9, 64'h5, 0, 0, 1, 1, 12'h300, 64'hAA, 0, 0));
    wait_cap();
    repeat (2) begin
      chk("csr_hold_cpl", rob_cpl_valid_o, 64'd0);
      chk("csr_hold_req", csr_wr_valid_o, 64'd1);
      tick();
    end
    csr_rdy = 1'b1;
    #1;
    chk("csr_both", {csr_wr_valid_o, rob_cpl_valid_o}, 64'd3);
    chk("csr_addr_dir", csr_wr_address_o, 64'h300);
    chk("csr_data_dir", csr_wr_data_o, 64'hAA);
    tick();
    chk("csr_popped", rob_cpl_valid_o, 64'd0);

    // streaming with wrap
    for (int i = 0; i < 10; i++) begin
      drive(mk(6'($urandom_range(0, 63)), 4'(i), 64'($urandom), 0, 0, 0, 0, 0, 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
      wait_cap();
      if (i > 0) chk("stream_occ", 64'(q.size()), 64'd1);
    end
    repeat (3) tick();

    // flush with 3 queued and an op arriving in the same cycle
    rob_rdy = 1'b0;
    for (int r = 0; r < 3; r++) begin
      drive(mk(6'(r + 10), 4'(r + 10), 64'(r), 0, 0, 0, 0, 0, 0, 1, 1));
      wait_cap();
    end
    drive(mk(6'd20, 4'd13, 64'h99, 0, 0, 0, 0, 0, 0, 0, 0));
    flush = 1'b1;
    rob_rdy = 1'b1;
    tick();
    flush = 1'b0;
    done = 1'b0;
    chk("flush_stall", stall_o, 64'd0);
    chk("flush_empty", rob_cpl_valid_o, 64'd0);
    repeat (3) tick();

    // reset mid-drain
    rob_rdy = 1'b0;
    for (int r = 0; r < 3; r++) begin
      drive(mk(6'(r + 30), 4'(r), 64'(r + 7), 0, 0, 0, 0, 0, 0, 1, 0));
      wait_cap();
    end
    rob_rdy = 1'b1;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rst2_cpl", rob_cpl_valid_o, 64'd0);
    chk("rst2_outs", {prf_wr_addr_o, rob_cpl_index_o, bpu_upd_jump_o, bpu_upd_pc_o}, 64'd0);
    repeat (3) tick();
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
